// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one synchronous read/write port of the CR16 data memory between
//   requester 0 (CPU data path) and requester 1 (auxiliary master).
//   Arbitration is round-robin with a bounded burst length. Each requester
//   gets its own read-valid strobe aligned to the memory's 1-cycle read latency.
//
// Handshake: a requester raises reqN (with weN/addrN/wdataN) and holds them
//   stable until it sees gntN high in the same cycle. That cycle the access is
//   presented to the memory. A read granted in cycle C returns rvalidN=1 and
//   rdataN in cycle C+1. There is no queuing and no backpressure on rvalid.
//
// Ports:
//   clk, rst_n              clock (rising edge), async active-low reset
//   req0/1, we0/1           access request, write(1)/read(0)
//   addr0/1, wdata0/1       word address, write data
//   gnt0/1                  access accepted this cycle (combinational)
//   rvalid0/1, rdata0/1     read data return, one cycle after grant
//   mem_wr_en, mem_addr,    memory port controls driven by the granted
//   mem_wr_data             requester (all zero when idle)
//   mem_rd_data             registered memory read data
module mem_port_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic [DATA_WIDTH-1:0] mem_rd_data
);

  localparam logic [3:0] MAX_B = 4'(MAX_BURST);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_R0   = 2'd1,
    OWN_R1   = 2'd2
  } owner_e;

  owner_e     owner_q, owner_d;
  logic       last_q, last_d;      // 0 = R0 granted most recently, 1 = R1
  logic [3:0] beats_q, beats_d;
  logic       rv0_q, rv0_d;
  logic       rv1_q, rv1_d;
  logic       g0, g1;

  // Grant decision. Gated by rst_n so nothing is granted while reset is held.
  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    if (rst_n) begin
      case ({req0, req1})
        2'b10: g0 = 1'b1;
        2'b01: g1 = 1'b1;
        2'b11: begin
          case (owner_q)
            OWN_R0: begin
              if (beats_q < MAX_B) g0 = 1'b1;
              else                 g1 = 1'b1;
            end
            OWN_R1: begin
              if (beats_q < MAX_B) g1 = 1'b1;
              else                 g0 = 1'b1;
            end
            default: begin
              // Idle last cycle: the requester not served most recently wins.
              if (last_q) g0 = 1'b1;
              else        g1 = 1'b1;
            end
          endcase
        end
        default: ;
      endcase
    end
  end

  // Next-state for ownership, burst counter and read-valid flags.
  always_comb begin
    owner_d = owner_q;
    beats_d = beats_q;
    last_d  = last_q;
    rv0_d   = g0 & ~we0;
    rv1_d   = g1 & ~we1;
    if (g0) begin
      last_d = 1'b0;
      if (owner_q == OWN_R0) begin
        beats_d = (beats_q >= MAX_B) ? MAX_B : beats_q + 4'd1;
      end else begin
        owner_d = OWN_R0;
        beats_d = 4'd1;
      end
    end else if (g1) begin
      last_d = 1'b1;
      if (owner_q == OWN_R1) begin
        beats_d = (beats_q >= MAX_B) ? MAX_B : beats_q + 4'd1;
      end else begin
        owner_d = OWN_R1;
        beats_d = 4'd1;
      end
    end else begin
      owner_d = OWN_NONE;
      beats_d = 4'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= OWN_NONE;
      last_q  <= 1'b1;
      beats_q <= 4'd0;
      rv0_q   <= 1'b0;
      rv1_q   <= 1'b0;
    end else begin
      owner_q <= owner_d;
      last_q  <= last_d;
      beats_q <= beats_d;
      rv0_q   <= rv0_d;
      rv1_q   <= rv1_d;
    end
  end

  // Memory port mux: granted requester drives the port, zeros when idle.
  always_comb begin
    mem_wr_en   = 1'b0;
    mem_addr    = '0;
    mem_wr_data = '0;
    if (g0) begin
      mem_wr_en   = we0;
      mem_addr    = addr0;
      mem_wr_data = wdata0;
    end else if (g1) begin
      mem_wr_en   = we1;
      mem_addr    = addr1;
      mem_wr_data = wdata1;
    end
  end

  assign gnt0    = g0;
  assign gnt1    = g1;
  assign rvalid0 = rv0_q;
  assign rvalid1 = rv1_q;
  // Memory echoes write data on mem_rd_data; only read-valid cycles pass it on.
  assign rdata0  = rv0_q ? mem_rd_data : '0;
  assign rdata1  = rv1_q ? mem_rd_data : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0, req1, we0, we1;
  logic [9:0]  addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [15:0] rdata0, rdata1;
  logic        mem_wr_en;
  logic [9:0]  mem_addr;
  logic [15:0] mem_wr_data;
  logic [15:0] mem_rd_data;

  int checks;
  int errors;

  logic [15:0] mem [0:1023];

  mem_port_arbiter #(.DATA_WIDTH(16), .ADDR_WIDTH(10), .MAX_BURST(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: reset loads mem[i] = 16'hA000 | i; writes echo write data.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 16'hA000 | 16'(i);
      mem_rd_data <= 16'h0000;
    end else if (mem_wr_en) begin
      mem[mem_addr] <= mem_wr_data;
      mem_rd_data   <= mem_wr_data;
    end else begin
      mem_rd_data <= mem[mem_addr];
    end
  end

  // Driver tasks
  task automatic drive(input logic r0, input logic w0, input logic [9:0] a0,
                       input logic [15:0] d0, input logic r1, input logic w1,
                       input logic [9:0] a1, input logic [15:0] d1);
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    drive(0, 0, 10'h0, 16'h0, 0, 0, 10'h0, 16'h0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1, 1, 10'h3FF, 16'hFFFF, 1, 0, 10'h2AA, 16'h5555);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({gnt0, gnt1, rvalid0, rvalid1, mem_wr_en} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 00000",
               {gnt0, gnt1, rvalid0, rvalid1, mem_wr_en});
    end
    checks++;
    if ({mem_addr, mem_wr_data, rdata0, rdata1} !== 58'h0) begin
      errors++;
      $display("FAIL reset_data: addr %h wdata %h rdata0 %h rdata1 %h expected all 0",
               mem_addr, mem_wr_data, rdata0, rdata1);
    end
    apply_reset();
  endtask

  task automatic test_write_read();
    apply_reset();
    next_cycle();
    drive(1, 1, 10'h005, 16'hBEEF, 0, 0, 10'h0, 16'h0);
    @(negedge clk);
    checks++;
    if ({gnt0, gnt1, mem_wr_en, rvalid0} !== 4'b1010) begin
      errors++;
      $display("FAIL wr_cycle_ctrl: got %b expected 1010", {gnt0, gnt1, mem_wr_en, rvalid0});
    end
    checks++;
    if (mem_addr !== 10'h005 || mem_wr_data !== 16'hBEEF) begin
      errors++;
      $display("FAIL wr_cycle_bus: addr %h data %h expected 005 beef", mem_addr, mem_wr_data);
    end
    next_cycle();
    drive(1, 0, 10'h005, 16'h0, 0, 0, 10'h0, 16'h0);
    @(negedge clk);
    checks++;
    if ({gnt0, mem_wr_en, rvalid0} !== 3'b100) begin
      errors++;
      $display("FAIL rd_cycle_ctrl: got %b expected 100 (no rvalid after write)",
               {gnt0, mem_wr_en, rvalid0});
    end
    next_cycle();
    drive(0, 0, 10'h0, 16'h0, 0, 0, 10'h0, 16'h0);
    @(negedge clk);
    checks++;
    if (gnt0 !== 1'b0 || rvalid0 !== 1'b1 || rdata0 !== 16'hBEEF) begin
      errors++;
      $display("FAIL rd_return: gnt0 %b rvalid0 %b rdata0 %h expected 0 1 beef",
               gnt0, rvalid0, rdata0);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (rvalid0 !== 1'b0 || rdata0 !== 16'h0) begin
      errors++;
      $display("FAIL rd_idle: rvalid0 %b rdata0 %h expected 0 0000", rvalid0, rdata0);
    end
  endtask

  task automatic test_burst();
    logic eg0, pg0;
    logic [3:0] exp_v;
    apply_reset();
    pg0 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      next_cycle();
      drive(1, 0, 10'h005, 16'h0, 1, 0, 10'h006, 16'h0);
      @(negedge clk);
      eg0 = ((i / 4) % 2) == 0;
      exp_v = {eg0, ~eg0, (i > 0) && pg0, (i > 0) && !pg0};
      checks++;
      if ({gnt0, gnt1, rvalid0, rvalid1} !== exp_v) begin
        errors++;
        $display("FAIL burst_ctrl cycle %0d: got %b expected %b", i,
                 {gnt0, gnt1, rvalid0, rvalid1}, exp_v);
      end
      checks++;
      if (rdata0 !== (exp_v[1] ? 16'hA005 : 16'h0) ||
          rdata1 !== (exp_v[0] ? 16'hA006 : 16'h0)) begin
        errors++;
        $display("FAIL burst_data cycle %0d: rdata0 %h rdata1 %h", i, rdata0, rdata1);
      end
      pg0 = eg0;
    end
  endtask

  task automatic test_solo_saturate();
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      drive(0, 0, 10'h0, 16'h0, 1, 0, 10'h020, 16'h0);
      @(negedge clk);
      checks++;
      if ({gnt0, gnt1} !== 2'b01) begin
        errors++;
        $display("FAIL solo_r1 cycle %0d: got %b expected 01", i, {gnt0, gnt1});
      end
    end
    next_cycle();
    drive(1, 0, 10'h030, 16'h0, 1, 0, 10'h020, 16'h0);
    @(negedge clk);
    checks++;
    if ({gnt0, gnt1} !== 2'b10 || mem_addr !== 10'h030) begin
      errors++;
      $display("FAIL saturated_handover: gnt %b addr %h expected 10 030", {gnt0, gnt1}, mem_addr);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if ({gnt0, gnt1} !== 2'b10) begin
      errors++;
      $display("FAIL new_owner_keeps: got %b expected 10", {gnt0, gnt1});
    end
  endtask

  task automatic test_tie_break();
    apply_reset();
    next_cycle();
    drive(1, 0, 10'h001, 16'h0, 0, 0, 10'h0, 16'h0);
    @(negedge clk);
    checks++;
    if ({gnt0, gnt1} !== 2'b10) begin
      errors++;
      $display("FAIL tie_setup: got %b expected 10", {gnt0, gnt1});
    end
    next_cycle();
    drive(0, 0, 10'h0, 16'h0, 0, 0, 10'h0, 16'h0);
    @(negedge clk);
    checks++;
    if ({gnt0, gnt1, mem_wr_en, mem_addr} !== 13'h0) begin
      errors++;
      $display("FAIL tie_idle: gnt %b wr %b addr %h expected all 0",
               {gnt0, gnt1}, mem_wr_en, mem_addr);
    end
    next_cycle();
    drive(1, 0, 10'h001, 16'h0, 1, 0, 10'h002, 16'h0);
    @(negedge clk);
    checks++;
    if ({gnt0, gnt1} !== 2'b01 || mem_addr !== 10'h002) begin
      errors++;
      $display("FAIL tie_break: gnt %b addr %h expected 01 002", {gnt0, gnt1}, mem_addr);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    next_cycle();
    drive(1, 0, 10'h3FF, 16'h0, 0, 0, 10'h0, 16'h0);
    @(negedge clk);
    checks++;
    if (gnt0 !== 1'b1 || mem_addr !== 10'h3FF) begin
      errors++;
      $display("FAIL top_addr_read: gnt0 %b addr %h expected 1 3ff", gnt0, mem_addr);
    end
    next_cycle();
    rst_n = 1'b0;
    drive(1, 0, 10'h3FF, 16'h0, 1, 1, 10'h111, 16'h7777);
    @(negedge clk);
    checks++;
    if ({gnt0, gnt1, rvalid0, rvalid1, mem_wr_en} !== 5'b0 || rdata0 !== 16'h0 ||
        rdata1 !== 16'h0 || mem_addr !== 10'h0 || mem_wr_data !== 16'h0) begin
      errors++;
      $display("FAIL mid_reset: ctrl %b rdata0 %h addr %h wdata %h expected all 0",
               {gnt0, gnt1, rvalid0, rvalid1, mem_wr_en}, rdata0, mem_addr, mem_wr_data);
    end
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({gnt0, gnt1, rvalid0} !== 3'b100) begin
      errors++;
      $display("FAIL post_reset_grant: got %b expected 100", {gnt0, gnt1, rvalid0});
    end
  endtask

  task automatic test_write_then_read_other();
    apply_reset();
    next_cycle();
    drive(1, 1, 10'h010, 16'h1234, 1, 0, 10'h010, 16'h0);
    @(negedge clk);
    checks++;
    if ({gnt0, gnt1, mem_wr_en} !== 3'b101 || mem_wr_data !== 16'h1234) begin
      errors++;
      $display("FAIL wr_vs_rd_a: ctrl %b wdata %h expected 101 1234",
               {gnt0, gnt1, mem_wr_en}, mem_wr_data);
    end
    next_cycle();
    drive(0, 0, 10'h0, 16'h0, 1, 0, 10'h010, 16'h0);
    @(negedge clk);
    checks++;
    if ({gnt0, gnt1, mem_wr_en, rvalid0, rvalid1} !== 5'b01000 || mem_addr !== 10'h010) begin
      errors++;
      $display("FAIL wr_vs_rd_b: ctrl %b addr %h expected 01000 010",
               {gnt0, gnt1, mem_wr_en, rvalid0, rvalid1}, mem_addr);
    end
    next_cycle();
    drive(0, 0, 10'h0, 16'h0, 0, 0, 10'h0, 16'h0);
    @(negedge clk);
    checks++;
    if (rvalid1 !== 1'b1 || rdata1 !== 16'h1234 || rvalid0 !== 1'b0) begin
      errors++;
      $display("FAIL wr_vs_rd_c: rvalid1 %b rdata1 %h rvalid0 %b expected 1 1234 0",
               rvalid1, rdata1, rvalid0);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    drive(0, 0, 10'h0, 16'h0, 0, 0, 10'h0, 16'h0);
    test_reset();
    test_write_read();
    test_burst();
    test_solo_saturate();
    test_tie_break();
    test_reset_mid();
    test_write_then_read_other();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one synchronous-read/write port of the CR16 dual-port data memory between two requesters.
- Requester 0 is the CPU data path; requester 1 is an auxiliary master (program loader, display fetch).
- The port is arbitrated round-robin with a bounded burst length, and each requester gets its own read-valid strobe aligned to the memory's 1-cycle read latency.

Parameters:
- DATA_WIDTH, 16, memory word width.
- ADDR_WIDTH, 10, memory address width (clog2 of a 1024-word memory).
- MAX_BURST, 4, maximum consecutive grants to one requester while the other is waiting; legal range 1 to 15.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0, req1  in  1 each  access request, held high while an access is wanted.
- we0, we1  in  1 each  1 = write, 0 = read; qualified by req.
- addr0, addr1  in  ADDR_WIDTH each  word address.
- wdata0, wdata1  in  DATA_WIDTH each  write data.
- gnt0, gnt1  out  1 each  access accepted this cycle.
- rvalid0, rvalid1  out  1 each  read data valid.
- rdata0, rdata1  out  DATA_WIDTH each  read data.
- mem_wr_en  out  1  to the memory port write enable.
- mem_addr  out  ADDR_WIDTH  to the memory port address.
- mem_wr_data  out  DATA_WIDTH  to the memory port write data.
- mem_rd_data  in  DATA_WIDTH  from the memory port read data; registered, valid one cycle after the address.

Behaviour:
- Registered state:
  - owner: NONE, R0 or R1 (the requester granted last cycle).
  - last: requester granted most recently, ever.
  - beats: consecutive grant count, saturating at MAX_BURST.
  - rv0, rv1: read-valid flags.
- Reset (async, rst_n low): owner=NONE, last=R1 (so R0 wins the first tie), beats=0, rv0=rv1=0.
- Outputs during reset: gnt0=gnt1=0, rvalid0=rvalid1=0, rdata0=rdata1=0, mem_wr_en=0, mem_addr=0, mem_wr_data=0.
- Grant decision is combinational from req0/req1 and registered state. At most one gnt is high per cycle.
- Grant rules:
  - Neither requesting: no grant.
  - Only one requesting: grant it, regardless of beats.
  - Both requesting and owner is that requester with beats < MAX_BURST: owner keeps the grant.
  - Both requesting and owner is that requester with beats == MAX_BURST: grant the other requester.
  - Both requesting and owner is NONE: grant the requester not equal to last.
- Memory mux:
  - Granted requester's we/addr/wdata drive mem_wr_en/mem_addr/mem_wr_data in the same cycle.
  - With no grant: mem_wr_en=0 and mem_addr/mem_wr_data=0.
- A request not granted is simply not accepted. The requester holds req/we/addr/wdata stable until gnt is seen; no queuing inside the block.
- Clock-edge updates:
  - Same requester as owner granted: beats = min(beats+1, MAX_BURST).
  - Different requester granted: beats = 1 and owner = the new requester.
  - No grant: owner=NONE and beats=0.
  - Any grant: last is updated to that requester.
- Read latency: a read granted in cycle C gives rvalidN=1 in cycle C+1, and rdataN=mem_rd_data in that cycle. Otherwise rdataN=0.
  - Registered as rvN <= gntN & ~weN.
  - Writes never raise rvalid, even though the memory echoes write data on mem_rd_data.
- Back-to-back reads by one requester: rvalid stays high on consecutive cycles, and each cycle's data belongs to the previous cycle's address.
- Ownership change from R0 read to R1 read: rvalid0 in C+1 and rvalid1 in C+2. No overlap and no lost data.
- Reset mid-operation: a pending rvalid is dropped and the memory access in flight is discarded from the requester's view.
- MAX_BURST=1 gives strict alternation under continuous contention.

Test Plan:
- Reset release, req0=1 we0=1 addr0=0x005 wdata0=0xBEEF, one cycle, then req0=1 we0=0 addr0=0x005 -> gnt0 high both cycles; mem_wr_en=1 first cycle only; rvalid0=1 with rdata0=0xBEEF on the cycle after the read; rvalid0 stays 0 after the write.
- Both req high continuously with reads, MAX_BURST=4, from reset -> gnt0 for 4 cycles, gnt1 for 4, gnt0 for 4, and so on; never both high; rvalid pattern is the gnt pattern delayed by 1.
- req1 alone high for 10 cycles -> gnt1 all 10 cycles (no burst cutoff); then req0 also rises -> since beats has saturated at MAX_BURST, gnt0 is granted in that same cycle.
- Idle cycle between two simultaneous requests after last=R0 -> R1 granted first (round-robin tie-break).
- Read granted to R0 at addr 0x3FF (top address) with rst_n pulsed low the following cycle -> rvalid0=0, rdata0=0, all outputs zero while reset is low; first grant after release is R0.
- R0 writes 0x1234 to 0x010 while R1 requests a read of 0x010 in the same cycle -> R0 granted, write happens; R1 granted next cycle; rdata1=0x1234 with rvalid1 one cycle later.
